// File: rtl/boot_loader.sv
// Framed byte-stream program loader: parses SYNC/LEN/BASE/DATA/CSUM frames,
// writes the payload through the CPU memory write port and holds the CPU in
// reset until a frame with a good checksum has been loaded.
module boot_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RST_HOLD  = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StBase,
    StData,
    StCsum,
    StRelease,
    StRun,
    StError
  } state_e;

  state_e            state_q, state_d;
  // Remaining data bytes; 9 bits so LEN=0 can stand for 256.
  logic [8:0]        count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        hold_q, hold_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_rstn_q, cpu_rstn_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [7:0]        csum_sum;

  // Readiness is a pure state decode so upstream never sees a data-dependent ready.
  assign rx_ready = (state_q == StIdle) || (state_q == StLen) || (state_q == StBase) ||
                    (state_q == StData) || (state_q == StCsum);
  assign accept   = rx_valid && rx_ready;
  assign csum_sum = csum_q + rx_data;

  // Frame parser, write-port and CPU-reset next-state logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    csum_d      = csum_q;
    hold_d      = hold_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          csum_d  = '0;
          state_d = StLen;
        end
      end
      StLen: begin
        if (accept) begin
          count_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          csum_d  = csum_sum;
          state_d = StBase;
        end
      end
      StBase: begin
        if (accept) begin
          addr_d  = ADDR_W'(rx_data);
          csum_d  = csum_sum;
          state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = rx_data;
          addr_d      = addr_q + 1'b1;
          count_d     = count_q - 9'd1;
          csum_d      = csum_sum;
          if (count_q == 9'd1) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (accept) begin
          csum_d = csum_sum;
          if (csum_sum == 8'h00) begin
            hold_d  = 8'(RST_HOLD);
            state_d = StRelease;
          end else begin
            state_d = StError;
          end
        end
      end
      StRelease: begin
        // Counts down from RST_HOLD so the CPU leaves reset RST_HOLD+1 edges after CSUM.
        if (hold_q == 8'h00) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      StRun: begin
        if (load_req) begin
          state_d = StIdle;
        end
      end
      StError: begin
        if (load_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status outputs are registered from the next state to stay glitch-free.
    cpu_rstn_d = (state_d == StRun);
    done_d     = (state_d == StRun);
    err_d      = (state_d == StError);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      count_q     <= '0;
      addr_q      <= '0;
      csum_q      <= '0;
      hold_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rstn_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      csum_q      <= csum_d;
      hold_q      <= hold_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rstn_q  <= cpu_rstn_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rstn  = cpu_rstn_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: table-driven frames, hand-written corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_boot_loader;

  localparam int unsigned AddrW   = 8;
  localparam int unsigned RstHold = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             load_req;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [7:0]       mem_wdata;
  logic             cpu_rstn;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  boot_loader #(
    .ADDR_W   (AddrW),
    .RST_HOLD (RstHold),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .load_req (load_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rstn (cpu_rstn),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  typedef struct {
    int         n;
    logic [7:0] b [10];
    int         gap;
    bit         good;
  } vec_t;

  wr_t        wr_q[$];
  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  vec_t       vecs[4];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         lr_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor.
  always @(negedge clk) begin
    if (mem_we) wr_q.push_back('{mem_addr, mem_wdata, cyc});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Idle cycles, optionally with stray load_req pulses that must be ignored.
  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      load_req = lr_en && ($urandom_range(0, 4) == 0);
      @(negedge clk);
      load_req = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    n        = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Frame-level reference: find SYNC, then derive writes and checksum verdict.
  task automatic model(output bit good);
    int         i;
    int         n;
    logic [7:0] base;
    logic [7:0] sum;
    exp_q.delete();
    i = 0;
    while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
    n    = (frame_q[i+1] == 8'h00) ? 256 : int'(frame_q[i+1]);
    base = frame_q[i+2];
    sum  = frame_q[i+1] + base;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{8'(int'(base) + k), frame_q[i+3+k], 0});
      sum = sum + frame_q[i+3+k];
    end
    sum  = sum + frame_q[i+3+n];
    good = (sum == 8'h00);
  endtask

  task automatic run_frame(input int gap_max);
    wr_q.delete();
    foreach (frame_q[i]) begin
      idle((gap_max == 0) ? 0 : $urandom_range(0, gap_max));
      send(frame_q[i]);
    end
  endtask

  task automatic compare_writes(input bit b2b);
    check("wr_count", 32'(wr_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++) begin
      check("wr_addr", 32'(wr_q[k].addr), 32'(exp_q[k].addr));
      check("wr_data", 32'(wr_q[k].data), 32'(exp_q[k].data));
      if (b2b && k > 0) check("wr_b2b", 32'(wr_q[k].cyc - wr_q[k-1].cyc), 32'd1);
    end
    if (exp_q.size() > 0) begin
      check("we_idle", 32'(mem_we), 32'd0);
      check("addr_hold", 32'(mem_addr), 32'(exp_q[exp_q.size()-1].addr));
      check("data_hold", 32'(mem_wdata), 32'(exp_q[exp_q.size()-1].data));
    end
  endtask

  // Entered at the negedge right after the CSUM-accepting edge.
  task automatic finish_check(input bit good, input bit b2b);
    if (good) begin
      check("release_rstn", 32'(cpu_rstn), 32'd0);
      repeat (RstHold) @(negedge clk);
      check("release_late_rstn", 32'(cpu_rstn), 32'd0);
      @(negedge clk);
      check("run_rstn", 32'(cpu_rstn), 32'd1);
      check("run_done", 32'(done), 32'd1);
      check("run_err", 32'(err), 32'd0);
      check("run_ready", 32'(rx_ready), 32'd0);
    end else begin
      check("err_set", 32'(err), 32'd1);
      check("err_rstn", 32'(cpu_rstn), 32'd0);
      repeat (6) @(negedge clk);
      check("err_held", 32'(err), 32'd1);
      check("err_rstn_held", 32'(cpu_rstn), 32'd0);
      check("err_done", 32'(done), 32'd0);
    end
    compare_writes(b2b);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("reload_ready", 32'(rx_ready), 32'd1);
    check("reload_err", 32'(err), 32'd0);
    check("reload_done", 32'(done), 32'd0);
    check("reload_rstn", 32'(cpu_rstn), 32'd0);
  endtask

  initial begin
    bit         good;
    int         ngarb;
    int         len;
    int         gap;
    logic [7:0] sum;
    logic [7:0] b;

    vecs[0] = '{7, '{8'hA5, 8'h03, 8'h00, 8'h88, 8'h89, 8'h24, 8'hC8, 8'h00, 8'h00, 8'h00}, 0, 1'b1};
    vecs[1] = '{7, '{8'hA5, 8'h03, 8'h00, 8'h88, 8'h89, 8'h24, 8'hC7, 8'h00, 8'h00, 8'h00}, 0, 1'b0};
    vecs[2] = '{7, '{8'hA5, 8'h03, 8'hFE, 8'h11, 8'h22, 8'h33, 8'h99, 8'h00, 8'h00, 8'h00}, 0, 1'b1};
    vecs[3] = '{9, '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h10, 8'hAA, 8'hBB, 8'h89, 8'h00}, 2, 1'b1};

    rstn     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rstn", 32'(cpu_rstn), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(rx_ready), 32'd1);

    // Table-driven frames: good, bad checksum then recovery, wrap, garbage with gaps.
    for (int v = 0; v < 4; v++) begin
      frame_q.delete();
      for (int i = 0; i < vecs[v].n; i++) frame_q.push_back(vecs[v].b[i]);
      run_frame(vecs[v].gap);
      model(good);
      finish_check(vecs[v].good, vecs[v].gap == 0 && frame_q[0] == 8'hA5);
    end

    // Full 256-byte frame.
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h00);
    frame_q.push_back(8'h00);
    for (int i = 0; i < 256; i++) frame_q.push_back(8'(i));
    frame_q.push_back(8'h80);
    run_frame(0);
    model(good);
    if (wr_q.size() > 0) begin
      check("full_last_addr", 32'(wr_q[wr_q.size()-1].addr), 32'hFF);
      check("full_last_data", 32'(wr_q[wr_q.size()-1].data), 32'hFF);
    end
    finish_check(1'b1, 1'b1);

    // Reset in the middle of DATA, then reload.
    send(8'hA5);
    send(8'h03);
    send(8'h00);
    send(8'h88);
    send(8'h89);
    rstn = 1'b0;
    #1;
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_rstn", 32'(cpu_rstn), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(rx_ready), 32'd1);
    check("midrst_we_after", 32'(mem_we), 32'd0);
    frame_q.delete();
    for (int i = 0; i < vecs[0].n; i++) frame_q.push_back(vecs[0].b[i]);
    run_frame(0);
    model(good);
    finish_check(1'b1, 1'b1);

    // Randomized frames with gaps, leading garbage, stray load_req and bad checksums.
    lr_en = 1'b1;
    for (int t = 0; t < 30; t++) begin
      frame_q.delete();
      ngarb = $urandom_range(0, 2);
      for (int i = 0; i < ngarb; i++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        frame_q.push_back(b);
      end
      frame_q.push_back(8'hA5);
      len = $urandom_range(1, 20);
      b   = 8'($urandom);
      frame_q.push_back(8'(len));
      frame_q.push_back(b);
      sum = 8'(len) + b;
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        frame_q.push_back(b);
        sum = sum + b;
      end
      b = 8'h00 - sum;
      if ($urandom_range(0, 3) == 0) b = b ^ 8'(1 + $urandom_range(0, 254));
      frame_q.push_back(b);
      gap = $urandom_range(0, 2);
      run_frame(gap);
      model(good);
      finish_check(good, gap == 0 && ngarb == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
